player_bullet: RTL
==================

Name: player_bullet

Overview:
- Player missile stage; sits directly downstream of the player movement block.
- Consumes the player X position and the keyboard keycode, and launches a single bullet from the cannon tip.
- Moves the bullet upward once per frame and retires it on hit or at the top of the screen.
- Drives bullet position and active flag to the collision logic and the colour mapper.

Parameters:
- FIRE_KEY, 8'h2C, keycode that fires (space bar).
- X_OFFSET, 10'd15, added to player_X to centre the bullet on the cannon.
- Y_START, 10'd440, bullet Y on launch frame.
- Y_MIN, 10'd16, topmost legal bullet Y; retire when the next step would pass it.
- Y_STEP, 10'd4, pixels moved upward per frame.
- COOLDOWN_FRAMES, 8, frames after retirement before the next launch is allowed (must be >= 1).

Ports:
- frame_clk  input  1  frame-rate clock (one edge per vsync); all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- keycode  input  8  current keyboard keycode; 8'h00 = no key.
- player_X  input  10  current player X position.
- hit  input  1  collision logic reports that the bullet struck an invader or shield this frame.
- bullet_X  output  10  bullet X position.
- bullet_Y  output  10  bullet Y position.
- bullet_active  output  1  bullet is on screen and should be drawn and collision-checked.
- fired  output  1  one-frame pulse on the launch frame (sound/score hooks).

Behaviour:
- One clock (frame_clk); reset is synchronous and active-high (Reset); sampled only on the frame_clk rising edge.
- Reset values: state=IDLE, bullet_X=0, bullet_Y=Y_START, bullet_active=0, fired=0, cooldown counter=0, fire_armed=1.
- fire_armed: cleared on launch; set on any frame where keycode != FIRE_KEY. A launch requires fire_armed=1, so the key must be released between shots.
- fire_req = (keycode == FIRE_KEY) && fire_armed.
- IDLE:
  - On fire_req, go to FLYING.
  - Latch bullet_X = player_X + X_OFFSET (10-bit, wraps mod 1024; no clamp).
  - Set bullet_Y = Y_START and bullet_active=1; pulse fired=1 for that frame only.
  - hit is ignored in IDLE.
- FLYING, evaluated in priority order each frame:
  - (1) hit=1: retire.
  - (2) bullet_Y < Y_MIN + Y_STEP: retire (off-top; the comparison prevents unsigned underflow/wrap).
  - (3) Otherwise bullet_Y <= bullet_Y - Y_STEP.
  - bullet_X is held constant; later player_X changes do not move the bullet.
  - Fire key is ignored while FLYING; fire_armed still tracks release.
- Retire: bullet_active <= 0, counter <= COOLDOWN_FRAMES-1, go to COOLDOWN; bullet_X and bullet_Y hold their last values.
- COOLDOWN: counter decrements each frame; at counter==0, go to IDLE on the next edge. fire_req is ignored during COOLDOWN.
- Latency:
  - Key-to-active is 1 frame (registered).
  - From retirement to the earliest relaunch is COOLDOWN_FRAMES+1 frames.
- hit and off-top on the same frame: treated as a hit (same retire path, no distinction at outputs).
- Reset mid-flight: on the next edge the block is in IDLE with bullet_active=0; no fired pulse.
- Reset held with the fire key pressed: no launch while Reset=1.
  - fire_armed=1 after Reset deasserts, so a key still held fires on the first frame out of reset.
- Counter width: $clog2(COOLDOWN_FRAMES)+1 bits.

Optional Feature:
- Macro: PLAYER_BULLET_AUTOFIRE_EN.
- Defined: fire_armed is forced to 1, so holding FIRE_KEY relaunches automatically on the first IDLE frame after each cooldown.
- Undefined: release-to-rearm behaviour exactly as above.

Decomposition:
- Shared package space_invaders_pkg:
  - bullet_state_t enum {IDLE, FLYING, COOLDOWN}.
  - Keycode constants KEY_A=8'h04, KEY_D=8'h07, KEY_SPACE=8'h2C.
  - SCREEN_W=640, SCREEN_H=480.
- No sub-module needed; the cooldown counter stays inline.

Test Plan:
- Launch: after reset, player_X=320, keycode=8'h2C for 1 frame -> next frame bullet_active=1, bullet_X=335, bullet_Y=440, fired=1; following frame fired=0, bullet_Y=436.
- Hold key, no autofire: keycode=8'h2C held for 200 frames -> exactly one fired pulse; bullet retires when bullet_Y=16 (16 < 20); release then press -> second launch after cooldown.
- Hit: launch, assert hit on the 5th flying frame -> bullet_active=0 on the next edge; relaunch refused for 8 frames and accepted on the 9th.
- Simultaneous: hit=1 on the frame bullet_Y=16 -> single retire, no underflow (bullet_Y never shows a value >1000).
- Reset mid-flight: Reset=1 for one edge while bullet_Y=300 -> bullet_active=0, state IDLE, fired=0, bullet_Y=440.
- Autofire (PLAYER_BULLET_AUTOFIRE_EN defined): key held -> fired pulses recur with period = flight frames + COOLDOWN_FRAMES + 1.

Source files
------------

// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the Space Invaders video/game pipeline.
// Holds the player-bullet state encoding, keyboard keycodes, screen size
// and a small helper used to decide whether a bullet has left the top.
package space_invaders_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } bullet_state_t;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // True when stepping up by step from y would pass the top limit.
    // Done in 11 bits so min+step can never wrap and y-step is never
    // evaluated below zero.
    function automatic logic off_top(input logic [9:0] y,
                                     input logic [9:0] y_min,
                                     input logic [9:0] y_step);
        return ({1'b0, y} < ({1'b0, y_min} + {1'b0, y_step}));
    endfunction

endpackage

// File: rtl/player_bullet.sv
// Player missile stage: launches one bullet from the cannon tip when the
// fire key is pressed, moves it up once per frame, retires it on a hit or
// at the top of the screen, then enforces a cooldown before relaunch.
// Build option: define PLAYER_BULLET_AUTOFIRE_EN to keep the fire key
// permanently armed so a held key relaunches after every cooldown.
module player_bullet
    import space_invaders_pkg::*;
#(
    parameter logic [7:0] FIRE_KEY        = KEY_SPACE,
    parameter logic [9:0] X_OFFSET        = 10'd15,
    parameter logic [9:0] Y_START         = 10'd440,
    parameter logic [9:0] Y_MIN           = 10'd16,
    parameter logic [9:0] Y_STEP          = 10'd4,
    parameter int         COOLDOWN_FRAMES = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [9:0] player_X,
    input  logic       hit,
    output logic [9:0] bullet_X,
    output logic [9:0] bullet_Y,
    output logic       bullet_active,
    output logic       fired
);

    localparam int CW = $clog2(COOLDOWN_FRAMES) + 1;
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_FRAMES - 1);

    bullet_state_t state_reg, state_next;
    logic [9:0]    x_reg, x_next;
    logic [9:0]    y_reg, y_next;
    logic          active_reg, active_next;
    logic          fired_reg, fired_next;
    logic [CW-1:0] count_reg, count_next;
    logic          armed_reg, armed_next;
    logic          fire_req;
    logic          launch;

    // A launch needs the key pressed and a release seen since the last shot.
    assign fire_req = (keycode == FIRE_KEY) && armed_reg;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_reg  <= IDLE;
            x_reg      <= 10'd0;
            y_reg      <= Y_START;
            active_reg <= 1'b0;
            fired_reg  <= 1'b0;
            count_reg  <= '0;
            armed_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            active_reg <= active_next;
            fired_reg  <= fired_next;
            count_reg  <= count_next;
            armed_reg  <= armed_next;
        end
    end

    // Next-state and datapath update; hit beats off-top while flying.
    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        active_next = active_reg;
        fired_next  = 1'b0;
        count_next  = count_reg;
        launch      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (fire_req) begin
                    state_next  = FLYING;
                    x_next      = player_X + X_OFFSET;
                    y_next      = Y_START;
                    active_next = 1'b1;
                    fired_next  = 1'b1;
                    launch      = 1'b1;
                end
            end
            FLYING: begin
                if (hit || off_top(y_reg, Y_MIN, Y_STEP)) begin
                    state_next  = COOLDOWN;
                    active_next = 1'b0;
                    count_next  = COOL_LOAD;
                end else begin
                    y_next = y_reg - Y_STEP;
                end
            end
            COOLDOWN: begin
                if (count_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                active_next = 1'b0;
            end
        endcase
    end

    // Fire-key arming: cleared by a launch, re-armed by any non-fire frame.
    always_comb begin
`ifdef PLAYER_BULLET_AUTOFIRE_EN
        armed_next = 1'b1;
`else
        armed_next = armed_reg;
        if (launch) begin
            armed_next = 1'b0;
        end else if (keycode != FIRE_KEY) begin
            armed_next = 1'b1;
        end
`endif
    end

    assign bullet_X      = x_reg;
    assign bullet_Y      = y_reg;
    assign bullet_active = active_reg;
    assign fired         = fired_reg;

endmodule
